regfile_writer: RTL and testbench

Write-side front end for the 8 x 32-bit register file. Accepts writeback results from the execute and memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. Drains one entry per cycle onto the register file write port (`waddr`, `dataIn`, `sto`). Returns forwarding data for the two read addresses so operand readers see writes that are still queued.

---
 rtl/regfile_writer.sv | 103 ++++++++++
 tb/tb_regfile_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writer
// Brief    : In-order write buffer in front of the register file write port,
//            with combinational forwarding of queued writes to two readers.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        dataIn,
    output logic                     sto,
    input  logic [ADDR_W-1:0]        raddr1,
    input  logic [ADDR_W-1:0]        raddr2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_idx;

    // Ready looks only at the registered count, so a full buffer refuses
    // a push even in a cycle that also pops.
    assign in_ready = (r_count != c_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_count != '0) & ~hold;

    assign sto     = w_pop;
    assign waddr   = w_pop ? r_mem_addr[r_rptr] : '0;
    assign dataIn  = w_pop ? r_mem_data[r_rptr] : '0;
    assign pending = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are unreachable while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= in_addr;
            r_mem_data[r_wptr] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + c_PTR_W'(i);
            if ((c_PTR_W + 1)'(i) < r_count) begin
                if (r_mem_addr[w_idx] == raddr1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = r_mem_data[w_idx];
                end
                if (r_mem_addr[w_idx] == raddr2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = r_mem_data[w_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writer
// Brief    : Directed self-checking bench for regfile_writer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        hold = 1'b0;
    logic [2:0]  waddr;
    logic [31:0] dataIn;
    logic        sto;
    logic [2:0]  raddr1 = '0;
    logic [2:0]  raddr2 = '0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  pending;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [8];

    regfile_writer #(.DATA_W(32), .ADDR_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .hold(hold),
        .waddr(waddr), .dataIn(dataIn), .sto(sto),
        .raddr1(raddr1), .raddr2(raddr2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Register file model driven by the write port
    always @(posedge clk) if (sto) rf[waddr] <= dataIn;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (sto !== 1'b0) begin errors++; $display("FAIL reset_sto: got %b want 0", sto); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin errors++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_addr = 3'd0; in_data = 32'hABCD1234; hold = 1'b0; raddr1 = 3'd0;
        #1;
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL single_prefwd: got %b want 0", fwd1_hit); end
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (sto !== 1'b1 || waddr !== 3'd0 || dataIn !== 32'hABCD1234) begin errors++; $display("FAIL single_write: got sto=%b a=%0d d=%h want 1/0/abcd1234", sto, waddr, dataIn); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending: got %0d want 1", pending); end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hABCD1234) begin errors++; $display("FAIL single_fwd: got %b/%h want 1/abcd1234", fwd1_hit, fwd1_data); end
        cyc();
        checks++; if (sto !== 1'b0 || waddr !== 3'd0 || dataIn !== 32'h0) begin errors++; $display("FAIL single_idle: got sto=%b a=%0d d=%h want 0/0/0", sto, waddr, dataIn); end
        checks++; if (pending !== 3'd0 || fwd1_hit !== 1'b0) begin errors++; $display("FAIL single_drained: got p=%0d hit=%b want 0/0", pending, fwd1_hit); end
        checks++; if (rf[0] !== 32'hABCD1234) begin errors++; $display("FAIL single_rf: got %h want abcd1234", rf[0]); end
    endtask

    task automatic test_fill_stall();
        hold = 1'b1; raddr1 = 3'd5; raddr2 = 3'd4;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_addr = 3'(k); in_data = 32'(k * 'h11);
            #1;
            checks++; if (in_ready !== (k <= 4)) begin errors++; $display("FAIL fill_ready%0d: got %b want %b", k, in_ready, (k <= 4)); end
            cyc();
        end
        #1;
        checks++; if (pending !== 3'd4 || in_ready !== 1'b0 || sto !== 1'b0) begin errors++; $display("FAIL fill_full: got p=%0d rdy=%b sto=%b want 4/0/0", pending, in_ready, sto); end
        checks++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b1 || fwd2_data !== 32'h44) begin errors++; $display("FAIL fill_fwd: got %b %b/%h want 0 1/44", fwd1_hit, fwd2_hit, fwd2_data); end
        hold = 1'b0;
        #1;
        checks++; if (sto !== 1'b1 || waddr !== 3'd1 || dataIn !== 32'h11 || in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_w1: got sto=%b a=%0d d=%h rdy=%b want 1/1/11/0", sto, waddr, dataIn, in_ready); end
        cyc();
        checks++; if (pending !== 3'd3 || waddr !== 3'd2 || dataIn !== 32'h22 || in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_w2: got p=%0d a=%0d d=%h rdy=%b want 3/2/22/1", pending, waddr, dataIn, in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (pending !== 3'd3 || waddr !== 3'd3 || dataIn !== 32'h33) begin errors++; $display("FAIL pushpop_w3: got p=%0d a=%0d d=%h want 3/3/33", pending, waddr, dataIn); end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h55) begin errors++; $display("FAIL wrap_fwd: got %b/%h want 1/55", fwd1_hit, fwd1_data); end
        cyc();
        checks++; if (pending !== 3'd2 || waddr !== 3'd4 || dataIn !== 32'h44) begin errors++; $display("FAIL drain_w4: got p=%0d a=%0d d=%h want 2/4/44", pending, waddr, dataIn); end
        cyc();
        checks++; if (pending !== 3'd1 || sto !== 1'b1 || waddr !== 3'd5 || dataIn !== 32'h55) begin errors++; $display("FAIL drain_w5: got p=%0d sto=%b a=%0d d=%h want 1/1/5/55", pending, sto, waddr, dataIn); end
        cyc();
        checks++; if (pending !== 3'd0 || sto !== 1'b0) begin errors++; $display("FAIL drain_end: got p=%0d sto=%b want 0/0", pending, sto); end
        checks++; if (rf[1] !== 32'h11 || rf[3] !== 32'h33 || rf[5] !== 32'h55) begin errors++; $display("FAIL fill_rf: got %h %h %h want 11 33 55", rf[1], rf[3], rf[5]); end
    endtask

    task automatic test_fwd_priority();
        logic [2:0]  pa [3] = '{3'd2, 3'd3, 3'd2};
        logic [31:0] pd [3] = '{32'h1, 32'h7, 32'h2};
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_addr = pa[k]; in_data = pd[k];
            cyc();
        end
        in_valid = 1'b0; raddr1 = 3'd2; raddr2 = 3'd3;
        #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2) begin errors++; $display("FAIL prio_fwd1: got %b/%h want 1/2", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h7) begin errors++; $display("FAIL prio_fwd2: got %b/%h want 1/7", fwd2_hit, fwd2_data); end
        raddr1 = 3'd6;
        #1;
        checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin errors++; $display("FAIL prio_miss: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
        raddr1 = 3'd2;
        hold = 1'b0;
        cyc();
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2 || waddr !== 3'd3) begin errors++; $display("FAIL prio_pop1: got %b/%h a=%0d want 1/2/3", fwd1_hit, fwd1_data, waddr); end
        cyc();
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2 || fwd2_hit !== 1'b0 || sto !== 1'b1) begin errors++; $display("FAIL prio_head: got %b/%h %b sto=%b want 1/2 0 1", fwd1_hit, fwd1_data, fwd2_hit, sto); end
        cyc();
        checks++; if (fwd1_hit !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL prio_empty: got %b p=%0d want 0/0", fwd1_hit, pending); end
    endtask

    task automatic test_back_to_back();
        hold = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_addr = 3'(k); in_data = 32'h100 + 32'(k);
            cyc();
            checks++; if (sto !== 1'b1 || waddr !== 3'(k) || dataIn !== 32'h100 + 32'(k) || pending !== 3'd1) begin errors++; $display("FAIL b2b_%0d: got sto=%b a=%0d d=%h p=%0d want 1/%0d/%h/1", k, sto, waddr, dataIn, pending, k % 8, 32'h100 + 32'(k)); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (sto !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL b2b_end: got sto=%b p=%0d want 0/0", sto, pending); end
        checks++; if (rf[7] !== 32'h10F || rf[0] !== 32'h108) begin errors++; $display("FAIL b2b_rf: got %h %h want 10f 108", rf[7], rf[0]); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1; raddr1 = 3'd6;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_addr = 3'd6; in_data = 32'hDEAD0000 + 32'(k);
            cyc();
        end
        in_valid = 1'b0; hold = 1'b0;
        #1;
        checks++; if (pending !== 3'd3 || sto !== 1'b1 || fwd1_hit !== 1'b1) begin errors++; $display("FAIL mid_pre: got p=%0d sto=%b hit=%b want 3/1/1", pending, sto, fwd1_hit); end
        #1 rst = 1'b0;
        #1;
        checks++; if (sto !== 1'b0 || waddr !== 3'd0 || dataIn !== 32'h0) begin errors++; $display("FAIL mid_port: got sto=%b a=%0d d=%h want 0/0/0", sto, waddr, dataIn); end
        checks++; if (pending !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_state: got p=%0d rdy=%b want 0/1", pending, in_ready); end
        checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin errors++; $display("FAIL mid_fwd: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
        rf[6] = 32'h0;
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (sto !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL mid_stale%0d: got sto=%b p=%0d want 0/0", k, sto, pending); end
            cyc();
        end
        checks++; if (rf[6] !== 32'h0) begin errors++; $display("FAIL mid_rf: got %h want 0", rf[6]); end
        in_valid = 1'b1; in_addr = 3'd4; in_data = 32'h5A5A;
        cyc();
        in_valid = 1'b0;
        checks++; if (sto !== 1'b1 || waddr !== 3'd4 || dataIn !== 32'h5A5A) begin errors++; $display("FAIL mid_after: got sto=%b a=%0d d=%h want 1/4/5a5a", sto, waddr, dataIn); end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_fill_stall();
        test_fwd_priority();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
